alt_vipitc_multi_sync_generation: RTL

ALT_VIPITC_MULTI_SYNC_GENERATION -- requirements
Module: alt_vipitc_multi_sync_generation

---
 rtl/alt_vipitc_sync_pkg.sv | 20 ++
 rtl/alt_vipitc_sync_frame_counter.sv | 55 +++++
 rtl/alt_vipitc_multi_sync_generation.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alt_vipitc_sync_pkg.sv
// Shared types and helpers for the multi-channel sync generator.
package alt_vipitc_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } sync_state_e;

    localparam int DEF_NUM_SYNC = 2;
    localparam int DEF_H_W      = 14;
    localparam int DEF_V_W      = 13;
    localparam int DEF_PULSE_W  = 4;

    // Last counter value of a line/frame; totals may already be stored as (total-1).
    function automatic logic [31:0] frame_top(input logic [31:0] total, input bit minus_one);
        return minus_one ? total : total - 32'd1;
    endfunction

endpackage

// File: rtl/alt_vipitc_sync_frame_counter.sv
// Sample/line position counter with synchronous clear and count enable.
module alt_vipitc_sync_frame_counter
    import alt_vipitc_sync_pkg::*;
#(
    parameter int H_W              = DEF_H_W,
    parameter int V_W              = DEF_V_W,
    parameter int TOTALS_MINUS_ONE = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sclr_i,
    input  logic           en_i,
    input  logic [H_W-1:0] h_total_i,
    input  logic [V_W-1:0] v_total_i,
    output logic [H_W-1:0] h_o,
    output logic [V_W-1:0] v_o
);

    logic [H_W-1:0] h_q, h_d, h_top;
    logic [V_W-1:0] v_q, v_d, v_top;

    assign h_top = H_W'(frame_top(32'(h_total_i), TOTALS_MINUS_ONE != 0));
    assign v_top = V_W'(frame_top(32'(v_total_i), TOTALS_MINUS_ONE != 0));

    // >= rather than == so a total that shrinks mid-frame wraps on the next count.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (sclr_i) begin
            h_d = '0;
            v_d = '0;
        end else if (en_i) begin
            if (h_q >= h_top) begin
                h_d = '0;
                v_d = (v_q >= v_top) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_o = h_q;
    assign v_o = v_q;

endmodule

// File: rtl/alt_vipitc_multi_sync_generation.sv
// Multi-channel sync pulse generator locked to the measured frame timing.
// Optional output divider is built only when ALT_VIPITC_SYNC_DIVIDER_EN is defined.
module alt_vipitc_multi_sync_generation
    import alt_vipitc_sync_pkg::*;
#(
    parameter int NUM_SYNC         = DEF_NUM_SYNC,
    parameter int H_W              = DEF_H_W,
    parameter int V_W              = DEF_V_W,
    parameter int PULSE_W          = DEF_PULSE_W,
    parameter int TOTALS_MINUS_ONE = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stable,
    input  logic                        h_total_valid,
    input  logic                        v_total_valid,
    input  logic [H_W-1:0]              h_total,
    input  logic [V_W-1:0]              v_total,
    input  logic                        start_of_vsync,
    input  logic                        field_prediction,
    input  logic                        clear_enable,
    input  logic                        enable_count,
    input  logic                        output_enable,
    input  logic [NUM_SYNC*H_W-1:0]     trig_sample,
    input  logic [NUM_SYNC*V_W-1:0]     trig_line,
    input  logic [NUM_SYNC*PULSE_W-1:0] pulse_len,
    input  logic [H_W-1:0]              divider_value,
    output logic [NUM_SYNC-1:0]         sync_out,
    output logic                        locked,
    output logic                        div
);

    sync_state_e         state_q, state_d;
    logic                sof_f0, valid, count, locked_q;
    logic [H_W-1:0]      h_cnt;
    logic [V_W-1:0]      v_cnt;
    logic [NUM_SYNC-1:0] fire;

    assign sof_f0 = start_of_vsync & ~field_prediction;
    assign valid  = stable & h_total_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = ST_ARMED;
            ST_ARMED: if (sof_f0) state_d = ST_RUN;
            ST_RUN:   if (clear_enable && !sof_f0) state_d = ST_ARMED;
            default:  state_d = ST_IDLE;
        endcase
        if (!valid) state_d = ST_IDLE;
    end

    assign count = enable_count &
                   ((state_q == ST_RUN) | ((state_q == ST_ARMED) & sof_f0 & valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            locked_q <= output_enable & (state_d == ST_RUN) & v_total_valid;
        end
    end

    assign locked = locked_q;

    alt_vipitc_sync_frame_counter #(
        .H_W              (H_W),
        .V_W              (V_W),
        .TOTALS_MINUS_ONE (TOTALS_MINUS_ONE)
    ) u_frame_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclr_i    (sof_f0),
        .en_i      (count),
        .h_total_i (h_total),
        .v_total_i (v_total),
        .h_o       (h_cnt),
        .v_o       (v_cnt)
    );

    for (genvar i = 0; i < NUM_SYNC; i++) begin : g_ch
        logic [PULSE_W-1:0] len, rem_q, rem_d;
        logic               act_q, act_d;

        assign len     = pulse_len[i*PULSE_W +: PULSE_W];
        assign fire[i] = count & (h_cnt == trig_sample[i*H_W +: H_W])
                               & (v_cnt == trig_line[i*V_W +: V_W]);

        // rem_q counts the remaining high cycles after the current one; a zero length acts as one.
        always_comb begin
            act_d = act_q;
            rem_d = rem_q;
            if (!output_enable) begin
                act_d = 1'b0;
                rem_d = '0;
            end else if (act_q) begin
                if (rem_q == '0) act_d = 1'b0;
                else             rem_d = rem_q - 1'b1;
            end else if (fire[i]) begin
                act_d = 1'b1;
                rem_d = (len == '0) ? '0 : len - 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act_q <= 1'b0;
                rem_q <= '0;
            end else begin
                act_q <= act_d;
                rem_q <= rem_d;
            end
        end

        assign sync_out[i] = act_q;
    end

`ifdef ALT_VIPITC_SYNC_DIVIDER_EN
    logic [H_W-1:0] dcnt_q, dcnt_d;
    logic           arm_q, arm_d, div_q, div_d;

    // Channel 0 re-phases the divider; it then free-runs on counted cycles only.
    always_comb begin
        dcnt_d = dcnt_q;
        arm_d  = arm_q;
        div_d  = 1'b0;
        if (!output_enable) begin
            arm_d  = 1'b0;
            dcnt_d = '0;
        end else if (fire[0]) begin
            arm_d  = 1'b1;
            dcnt_d = '0;
        end else if (arm_q && count && divider_value != '0) begin
            if (dcnt_q >= divider_value - 1'b1) begin
                dcnt_d = '0;
                div_d  = 1'b1;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q <= '0;
            arm_q  <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            dcnt_q <= dcnt_d;
            arm_q  <= arm_d;
            div_q  <= div_d;
        end
    end

    assign div = div_q;
`else
    logic unused_divider;
    assign unused_divider = ^divider_value;
    assign div            = 1'b0;
`endif

endmodule
